// File: rtl/uart_pkg.sv
// Shared UART definitions: payload width and the receive-buffer entry layout.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef struct packed {
    logic                   parity_err;
    logic [UART_DATA_W-1:0] data;
  } rx_entry_t;

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Receive FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module uart_rx_fifo_mem #(
  parameter int WIDTH  = 9,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Write port; contents are intentionally left unreset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive buffer behind the UART rx controller, with sticky
// overrun and a saturating parity-error counter.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ERR_W  = 8
) (
  input  logic              clk_50M,
  input  logic              reset_n,
  input  logic              full,
  input  logic [DATA_W-1:0] read_value,
  input  logic              read_error,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_parity_err,
  output logic              empty,
  output logic              fifo_full,
  output logic [$clog2(DEPTH):0] count,
  output logic              overrun,
  input  logic              clr_overrun,
  output logic [ERR_W-1:0]  err_cnt
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0]  DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] cnt, input logic en);
    sat_inc = (en && (cnt != ERR_MAX)) ? cnt + {{(ERR_W-1){1'b0}}, 1'b1} : cnt;
  endfunction

  logic              full_d_r;
  logic [ADDR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [ADDR_W:0]   count_r, count_nxt_s;
  logic              empty_r, fifo_full_r, overrun_r;
  logic [ERR_W-1:0]  err_cnt_r;
  logic              push_s, pop_s, wr_ok_s, drop_s;
  rx_entry_t         wr_entry_s, head_s;

  assign push_s  = full & ~full_d_r;
  assign pop_s   = rd_en & ~empty_r;
  // A full FIFO still accepts a push when the same cycle frees the head slot.
  assign wr_ok_s = push_s & (~fifo_full_r | pop_s);
  assign drop_s  = push_s & fifo_full_r & ~pop_s;

  assign wr_entry_s.parity_err = read_error;
  assign wr_entry_s.data       = read_value;

  uart_rx_fifo_mem #(
    .WIDTH  (DATA_W + 1),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk_50M),
    .we    (wr_ok_s),
    .waddr (wr_ptr_r),
    .wdata (wr_entry_s),
    .raddr (rd_ptr_r),
    .rdata (head_s)
  );

  // Next occupancy from accepted push/pop.
  always_comb begin
    count_nxt_s = count_r;
    case ({wr_ok_s, pop_s})
      2'b10:   count_nxt_s = count_r + {{ADDR_W{1'b0}}, 1'b1};
      2'b01:   count_nxt_s = count_r - {{ADDR_W{1'b0}}, 1'b1};
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointers, occupancy, registered flags, edge detect, overrun and error count.
  always_ff @(posedge clk_50M or negedge reset_n) begin
    if (!reset_n) begin
      full_d_r    <= 1'b1;
      wr_ptr_r    <= {ADDR_W{1'b0}};
      rd_ptr_r    <= {ADDR_W{1'b0}};
      count_r     <= {(ADDR_W+1){1'b0}};
      empty_r     <= 1'b1;
      fifo_full_r <= 1'b0;
      overrun_r   <= 1'b0;
      err_cnt_r   <= {ERR_W{1'b0}};
    end else begin
      full_d_r    <= full;
      count_r     <= count_nxt_s;
      empty_r     <= (count_nxt_s == {(ADDR_W+1){1'b0}});
      fifo_full_r <= (count_nxt_s == DEPTH_C);
      err_cnt_r   <= sat_inc(err_cnt_r, wr_ok_s & read_error);
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
      if (drop_s) begin
        overrun_r <= 1'b1;
      end else if (clr_overrun) begin
        overrun_r <= 1'b0;
      end
    end
  end

  assign rd_data       = empty_r ? {DATA_W{1'b0}} : head_s.data;
  assign rd_parity_err = empty_r ? 1'b0 : head_s.parity_err;
  assign empty         = empty_r;
  assign fifo_full     = fifo_full_r;
  assign count         = count_r;
  assign overrun       = overrun_r;
  assign err_cnt       = err_cnt_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo; one task per scenario.
module tb_uart_rx_fifo;

  logic       clk_50M = 1'b0;
  logic       reset_n = 1'b0;
  logic       full = 1'b0;
  logic [7:0] read_value = 8'h00;
  logic       read_error = 1'b0;
  logic       rd_en = 1'b0;
  logic       clr_overrun = 1'b0;
  logic [7:0] rd_data;
  logic       rd_parity_err, empty, fifo_full, overrun;
  logic [4:0] count;
  logic [7:0] err_cnt;

  int vectors = 0;
  int miscompares = 0;

  uart_rx_fifo dut (
    .clk_50M(clk_50M), .reset_n(reset_n), .full(full), .read_value(read_value),
    .read_error(read_error), .rd_en(rd_en), .rd_data(rd_data),
    .rd_parity_err(rd_parity_err), .empty(empty), .fifo_full(fifo_full),
    .count(count), .overrun(overrun), .clr_overrun(clr_overrun), .err_cnt(err_cnt)
  );

  always #10 clk_50M = ~clk_50M;

  task automatic step();
    @(posedge clk_50M);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One frame: 'full' high for one cycle, then low so the next edge is seen.
  task automatic push_frame(input logic [7:0] v, input logic e);
    read_value = v; read_error = e; full = 1'b1;
    step();
    full = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    chk("reset_empty", empty, 1);
    chk("reset_count", count, 0);
    chk("reset_fifo_full", fifo_full, 0);
    chk("reset_overrun", overrun, 0);
    chk("reset_err_cnt", err_cnt, 0);
    chk("reset_rd_data", rd_data, 0);
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_single_edge();
    read_value = 8'hA5; read_error = 1'b0; full = 1'b1;
    step();
    chk("t1_count_after_edge", count, 1);
    chk("t1_empty_after_edge", empty, 0);
    chk("t1_rd_data", rd_data, 8'hA5);
    step(); step();
    chk("t1_count_held_level", count, 1);
    full = 1'b0;
    step();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("t1_empty_after_pop", empty, 1);
    chk("t1_rd_data_empty", rd_data, 0);
  endtask

  task automatic test_fill_overrun();
    for (int i = 0; i < 16; i++) push_frame(8'(i), 1'b0);
    chk("t2_fifo_full", fifo_full, 1);
    chk("t2_count16", count, 16);
    chk("t2_no_overrun_yet", overrun, 0);
    push_frame(8'hFF, 1'b0);
    chk("t2_overrun", overrun, 1);
    chk("t2_count_after_drop", count, 16);
    rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("t2_pop_order", rd_data, 8'(i));
      step();
    end
    rd_en = 1'b0;
    chk("t2_empty_after_drain", empty, 1);
    chk("t2_rd_data_empty", rd_data, 0);
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    chk("t2_overrun_cleared", overrun, 0);
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 16; i++) push_frame(8'h10 + 8'(i), 1'b0);
    chk("t3_full_before", fifo_full, 1);
    read_value = 8'h55; read_error = 1'b0; full = 1'b1; rd_en = 1'b1;
    step();
    full = 1'b0; rd_en = 1'b0;
    chk("t3_head_advanced", rd_data, 8'h11);
    chk("t3_count_stays", count, 16);
    chk("t3_fifo_full_stays", fifo_full, 1);
    chk("t3_no_overrun", overrun, 0);
    step();
    rd_en = 1'b1;
    for (int i = 1; i < 16; i++) begin
      chk("t3_pop_order", rd_data, 8'h10 + 8'(i));
      step();
    end
    chk("t3_last_is_55", rd_data, 8'h55);
    step();
    rd_en = 1'b0;
    chk("t3_empty_at_end", empty, 1);
  endtask

  task automatic test_empty_pop();
    rd_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_count0", count, 0);
      chk("t4_empty", empty, 1);
      chk("t4_rd_data0", rd_data, 0);
    end
    rd_en = 1'b0;
    // An undisturbed pointer pair shows the next push as the single head entry.
    push_frame(8'h3C, 1'b0);
    chk("t4_ptr_count", count, 1);
    chk("t4_ptr_head", rd_data, 8'h3C);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("t4_ptr_empty", empty, 1);
  endtask

  task automatic test_err_saturate();
    int bad_flag = 0;
    int bad_count = 0;
    rd_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      read_value = 8'(i); read_error = 1'b1; full = 1'b1;
      step();
      if (!empty && rd_parity_err !== 1'b1) bad_flag++;
      if (count > 1) bad_count++;
      full = 1'b0;
      step();
      if (!empty && rd_parity_err !== 1'b1) bad_flag++;
      if (i == 99) chk("t5_err_cnt_100", err_cnt, 100);
    end
    rd_en = 1'b0;
    read_error = 1'b0;
    chk("t5_err_cnt_sat", err_cnt, 255);
    chk("t5_parity_flags", bad_flag, 0);
    chk("t5_count_bound", bad_count, 0);
    chk("t5_empty_at_end", empty, 1);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) push_frame(8'h40 + 8'(i), 1'b0);
    chk("t6_count5", count, 5);
    @(negedge clk_50M);
    reset_n = 1'b0;
    #1;
    chk("t6_async_empty", empty, 1);
    chk("t6_async_count", count, 0);
    chk("t6_async_err_cnt", err_cnt, 0);
    full = 1'b1;
    step();
    reset_n = 1'b1;
    step(); step();
    chk("t6_no_capture_high_full", count, 0);
    full = 1'b0;
    step();
    for (int i = 0; i < 16; i++) push_frame(8'(i), 1'b0);
    read_value = 8'h99; full = 1'b1; clr_overrun = 1'b1;
    step();
    full = 1'b0; clr_overrun = 1'b0;
    chk("t6_drop_beats_clear", overrun, 1);
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    chk("t6_clear_after", overrun, 0);
    chk("t6_head_after_drop", rd_data, 8'h00);
  endtask

  initial begin
    test_reset();
    test_single_edge();
    test_fill_overrun();
    test_full_push_pop();
    test_empty_pop();
    test_err_saturate();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
